operand_fetcher: RTL and testbench

Downstream stage of operand selection. Once a selection completes, this block reads the chosen matrix slot(s) from matrix storage through a single synchronous read port, one element per cycle. It unpacks them into two flattened 5x5 operand buffers. It then signals the compute unit that operands are ready. Only matrix A is fetched for transpose and scalar operations; both A and B are fetched for add, multiply and convolution.

---
 rtl/operand_fetcher.sv | 214 +++++++++++++++++++++
 tb/tb_operand_fetcher.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetcher.sv
// operand_fetcher: reads the selected matrix slot(s) from storage one element
// per cycle and unpacks them into two flattened operand buffers.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start_fetch
// FETCH_A   | issuing reads for matrix A, one element per cycle
// FETCH_B   | issuing reads for matrix B, directly after A
// DRAIN     | no issue; last outstanding datum is captured
// DONE      | fetch_done pulse, buffers valid
// ERR       | fetch_error pulse, request rejected without any read
module operand_fetcher #(
  parameter int DATA_W    = 8,
  parameter int MAX_DIM   = 5,
  parameter int SLOT_SIZE = 25,
  parameter int ADDR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_fetch,
  input  logic [2:0]                  op_type,
  input  logic [3:0]                  id_a,
  input  logic [3:0]                  id_b,
  input  logic [2:0]                  a_m,
  input  logic [2:0]                  a_n,
  input  logic [2:0]                  b_m,
  input  logic [2:0]                  b_n,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,
  output logic [DATA_W*SLOT_SIZE-1:0] mat_a_flat,
  output logic [DATA_W*SLOT_SIZE-1:0] mat_b_flat,
  output logic [2:0]                  out_m_a,
  output logic [2:0]                  out_n_a,
  output logic [2:0]                  out_m_b,
  output logic [2:0]                  out_n_b,
  output logic                        busy,
  output logic                        fetch_done,
  output logic                        fetch_error
);

  localparam int FLAT_W = DATA_W * SLOT_SIZE;
  localparam int KW     = $clog2(SLOT_SIZE);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_A = 3'd1;
  localparam logic [2:0] S_FETCH_B = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [3:0]        MAX_ID   = 4'd9;
  localparam logic [2:0]        DIM_MAX  = 3'(MAX_DIM);
  localparam logic [ADDR_W-1:0] SLOT_W   = ADDR_W'(SLOT_SIZE);

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        id_a_q, id_a_d, id_b_q, id_b_d;
  logic [2:0]        m_a_q, m_a_d, n_a_q, n_a_d, m_b_q, m_b_d, n_b_q, n_b_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              tag_valid_q, tag_valid_d, tag_sel_b_q, tag_sel_b_d;
  logic [KW-1:0]     tag_k_q, tag_k_d;
  logic [FLAT_W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;

  logic [5:0] len_a, len_b;
  logic       last_a, last_b, req_need_b, req_ok;

  function automatic logic needs_b(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b011) || (op == 3'b100);
  endfunction

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= DIM_MAX);
  endfunction

  assign len_a  = 6'(m_a_q) * 6'(n_a_q);
  assign len_b  = 6'(m_b_q) * 6'(n_b_q);
  assign last_a = (6'(cnt_q) == len_a - 6'd1);
  assign last_b = (6'(cnt_q) == len_b - 6'd1);

  assign req_need_b = needs_b(op_type);
  assign req_ok     = (id_a <= MAX_ID) && dim_ok(a_m) && dim_ok(a_n) &&
                      (!req_need_b || ((id_b <= MAX_ID) && dim_ok(b_m) && dim_ok(b_n)));

  // Next-state, read issue, capture and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    id_a_d      = id_a_q;
    id_b_d      = id_b_q;
    m_a_d       = m_a_q;
    n_a_d       = n_a_q;
    m_b_d       = m_b_q;
    n_b_d       = n_b_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    tag_valid_d = mem_rd_en_q;
    tag_sel_b_d = (state_q == S_FETCH_B);
    tag_k_d     = cnt_q;

    // Data returns one cycle after the issue that produced the tag
    if (tag_valid_q) begin
      if (tag_sel_b_q) mat_b_d[tag_k_q*DATA_W +: DATA_W] = mem_rd_data;
      else             mat_a_d[tag_k_q*DATA_W +: DATA_W] = mem_rd_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start_fetch) begin
          op_d    = op_type;
          id_a_d  = id_a;
          id_b_d  = id_b;
          m_a_d   = a_m;
          n_a_d   = a_n;
          m_b_d   = req_need_b ? b_m : 3'd0;
          n_b_d   = req_need_b ? b_n : 3'd0;
          mat_a_d = '0;
          mat_b_d = '0;
          cnt_d   = '0;
          state_d = req_ok ? S_FETCH_A : S_ERR;
        end
      end
      S_FETCH_A: begin
        if (last_a) begin
          cnt_d   = '0;
          state_d = needs_b(op_q) ? S_FETCH_B : S_DRAIN;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_FETCH_B: begin
        if (last_b) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    mem_rd_en_d   = (state_d == S_FETCH_A) || (state_d == S_FETCH_B);
    mem_rd_addr_d = '0;
    if (mem_rd_en_d)
      mem_rd_addr_d = ADDR_W'((state_d == S_FETCH_B) ? id_b_d : id_a_d) * SLOT_W
                      + ADDR_W'(cnt_d);
    busy_d = mem_rd_en_d || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  // State and output registers; reset drops the read strobe and discards any tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      id_a_q        <= '0;
      id_b_q        <= '0;
      m_a_q         <= '0;
      n_a_q         <= '0;
      m_b_q         <= '0;
      n_b_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      tag_valid_q   <= 1'b0;
      tag_sel_b_q   <= 1'b0;
      tag_k_q       <= '0;
      mat_a_q       <= '0;
      mat_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      id_a_q        <= id_a_d;
      id_b_q        <= id_b_d;
      m_a_q         <= m_a_d;
      n_a_q         <= n_a_d;
      m_b_q         <= m_b_d;
      n_b_q         <= n_b_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      tag_valid_q   <= tag_valid_d;
      tag_sel_b_q   <= tag_sel_b_d;
      tag_k_q       <= tag_k_d;
      mat_a_q       <= mat_a_d;
      mat_b_q       <= mat_b_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mat_a_flat  = mat_a_q;
  assign mat_b_flat  = mat_b_q;
  assign out_m_a     = m_a_q;
  assign out_n_a     = n_a_q;
  assign out_m_b     = m_b_q;
  assign out_n_b     = n_b_q;
  assign busy        = busy_q;
  assign fetch_done  = done_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_operand_fetcher.sv
// Testbench for operand_fetcher: directed cases plus randomized requests,
// checked cycle by cycle against a slot/element reference model.
module tb_operand_fetcher;

  localparam int DATA_W = 8;
  localparam int FLAT_W = 200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_fetch = 1'b0;
  logic [2:0]        op_type = '0;
  logic [3:0]        id_a = '0, id_b = '0;
  logic [2:0]        a_m = '0, a_n = '0, b_m = '0, b_n = '0;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_addr;
  logic [7:0]        mem_rd_data = '0;
  logic [FLAT_W-1:0] mat_a_flat, mat_b_flat;
  logic [2:0]        out_m_a, out_n_a, out_m_b, out_n_b;
  logic              busy, fetch_done, fetch_error;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mem [0:255];

  operand_fetcher dut (
    .clk(clk), .rst_n(rst_n), .start_fetch(start_fetch), .op_type(op_type),
    .id_a(id_a), .id_b(id_b), .a_m(a_m), .a_n(a_n), .b_m(b_m), .b_n(b_n),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mat_a_flat(mat_a_flat), .mat_b_flat(mat_b_flat),
    .out_m_a(out_m_a), .out_n_a(out_n_a), .out_m_b(out_m_b), .out_n_b(out_n_b),
    .busy(busy), .fetch_done(fetch_done), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  // Synchronous storage model: data valid the cycle after the strobe
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"},  256'(mem_rd_en),   256'(0));
    check({tag, "_addr"},   256'(mem_rd_addr), 256'(0));
    check({tag, "_busy"},   256'(busy),        256'(0));
    check({tag, "_done"},   256'(fetch_done),  256'(0));
    check({tag, "_err"},    256'(fetch_error), 256'(0));
  endtask

  // One request, checked every cycle from accept to the done/error pulse.
  // poke=1 re-asserts start_fetch mid-fetch and in the DONE cycle.
  task automatic do_fetch(input logic [2:0] op, input int ia, input int ib,
                          input int am, input int an, input int bm, input int bn,
                          input bit poke);
    bit need_b, err;
    int addrs[$];
    logic [FLAT_W-1:0] exp_a, exp_b;
    int n;
    need_b = (op == 3'd1) || (op == 3'd3) || (op == 3'd4);
    err = (ia > 9) || am == 0 || am > 5 || an == 0 || an > 5 ||
          (need_b && ((ib > 9) || bm == 0 || bm > 5 || bn == 0 || bn > 5));
    exp_a = '0;
    exp_b = '0;
    if (!err) begin
      for (int k = 0; k < am * an; k++) begin
        addrs.push_back(ia * 25 + k);
        exp_a[k*DATA_W +: DATA_W] = mem[ia * 25 + k];
      end
      if (need_b)
        for (int k = 0; k < bm * bn; k++) begin
          addrs.push_back(ib * 25 + k);
          exp_b[k*DATA_W +: DATA_W] = mem[ib * 25 + k];
        end
    end
    n = addrs.size();

    @(negedge clk);
    op_type = op; id_a = 4'(ia); id_b = 4'(ib);
    a_m = 3'(am); a_n = 3'(an); b_m = 3'(bm); b_n = 3'(bn);
    start_fetch = 1'b1;
    @(negedge clk);
    start_fetch = 1'b0;

    if (err) begin
      check("err_pulse", 256'(fetch_error), 256'(1));
      check("err_busy",  256'(busy),        256'(0));
      check("err_rd_en", 256'(mem_rd_en),   256'(0));
      @(negedge clk);
      check_idle_outputs("err_after");
      check("err_mat_a", 256'(mat_a_flat), 256'(0));
      check("err_mat_b", 256'(mat_b_flat), 256'(0));
      return;
    end

    for (int c = 1; c <= n; c++) begin
      check("rd_en", 256'(mem_rd_en),   256'(1));
      check("addr",  256'(mem_rd_addr), 256'(addrs[c-1]));
      check("busy",  256'(busy),        256'(1));
      check("done",  256'(fetch_done | fetch_error), 256'(0));
      if (poke && c == 2) begin
        start_fetch = 1'b1;
        id_a = 4'd1; a_m = 3'd1; a_n = 3'd1;
      end else begin
        start_fetch = 1'b0;
      end
      @(negedge clk);
    end
    start_fetch = 1'b0;
    check("drain_rd_en", 256'(mem_rd_en),  256'(0));
    check("drain_busy",  256'(busy),       256'(1));
    check("drain_done",  256'(fetch_done), 256'(0));
    @(negedge clk);
    check("done_pulse", 256'(fetch_done),  256'(1));
    check("done_busy",  256'(busy),        256'(0));
    check("done_err",   256'(fetch_error), 256'(0));
    check("mat_a",      256'(mat_a_flat),  256'(exp_a));
    check("mat_b",      256'(mat_b_flat),  256'(exp_b));
    check("out_m_a",    256'(out_m_a), 256'(am));
    check("out_n_a",    256'(out_n_a), 256'(an));
    check("out_m_b",    256'(out_m_b), 256'(need_b ? bm : 0));
    check("out_n_b",    256'(out_n_b), 256'(need_b ? bn : 0));
    if (poke) start_fetch = 1'b1;
    @(negedge clk);
    start_fetch = 1'b0;
    check_idle_outputs("post_done");
    check("hold_mat_a", 256'(mat_a_flat), 256'(exp_a));
    check("hold_mat_b", 256'(mat_b_flat), 256'(exp_b));
    @(negedge clk);
    check("post_done_rd_en", 256'(mem_rd_en), 256'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    #1;
    check_idle_outputs("reset");
    check("reset_mat_a", 256'(mat_a_flat), 256'(0));
    check("reset_dims",  256'({out_m_a, out_n_a, out_m_b, out_n_b}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_fetch(3'd1, 2, 5, 2, 3, 2, 3, 1'b0);
    do_fetch(3'd0, 0, 7, 1, 1, 3, 3, 1'b0);
    do_fetch(3'd3, 8, 9, 5, 5, 5, 5, 1'b0);
    do_fetch(3'd1, 2, 5, 0, 3, 2, 3, 1'b0);
    do_fetch(3'd1, 2, 12, 2, 3, 2, 3, 1'b0);
    do_fetch(3'd2, 3, 12, 4, 2, 0, 0, 1'b0);
    do_fetch(3'd4, 6, 1, 5, 5, 3, 3, 1'b1);

    // Reset while fetching B
    @(negedge clk);
    op_type = 3'd3; id_a = 4'd3; id_b = 4'd4;
    a_m = 3'd5; a_n = 3'd5; b_m = 3'd5; b_n = 3'd5;
    start_fetch = 1'b1;
    @(negedge clk);
    start_fetch = 1'b0;
    repeat (27) @(negedge clk);
    check("pre_rst_rd_en", 256'(mem_rd_en), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    check("mid_rst_mat_a", 256'(mat_a_flat), 256'(0));
    check("mid_rst_mat_b", 256'(mat_b_flat), 256'(0));
    check("mid_rst_dims",  256'({out_m_a, out_n_a, out_m_b, out_n_b}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_rst");
    check("after_rst_mat_a", 256'(mat_a_flat), 256'(0));
    do_fetch(3'd3, 3, 4, 5, 5, 5, 5, 1'b0);

    // Randomized requests, mostly legal
    for (int r = 0; r < 40; r++) begin
      int ia, ib, am, an, bm, bn;
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      ia = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      ib = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      am = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
      an = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
      bm = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
      bn = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 5);
      do_fetch(op, ia, ib, am, an, bm, bn, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
